snn_step_sched: RTL and testbench
=================================

Name: snn_step_sched

Overview:
- Memory-mapped controller that sequences the SNN neuron-update datapath on behalf of the J1 core.
- J1 programs neuron count and timestep count over its I/O bus, then writes start.
- The block issues one update request per neuron per timestep through a valid/ready handshake, followed by one commit handshake per timestep.
- On completion it raises done/irq.
- Sits inside TOP_J1 between the J1 I/O decode and the SNN core.

Parameters:
- NEURON_W, 8, width of neuron index and neuron-count register (max 2^NEURON_W-1 neurons)
- STEP_W, 8, width of timestep index and step-count register
- DATA_W, 16, J1 I/O data width (must be >= NEURON_W, >= STEP_W, >= 8+STEP_W for STATUS)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- io_addr  in  2  register select: 0=CTRL, 1=NNEUR, 2=NSTEP, 3=STATUS
- io_wr  in  1  write strobe, one cycle
- io_rd  in  1  read strobe, one cycle
- io_din  in  DATA_W  write data
- io_dout  out  DATA_W  read data, registered
- upd_valid  out  1  neuron-update request valid
- upd_ready  in  1  datapath accepts update
- upd_neuron  out  NEURON_W  neuron index of request
- upd_step  out  STEP_W  timestep index of request
- upd_first  out  1  request is neuron 0 of its step
- cmt_valid  out  1  end-of-step commit request (fire/leak)
- cmt_ready  in  1  datapath accepts commit
- busy  out  1  sequence in progress
- done  out  1  sticky completion flag
- irq  out  1  done & irq_en

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; NNEUR=0, NSTEP=0, irq_en=0, indices=0.
- Registers: CTRL write bit0 start, bit1 abort, bit2 done_clr, bit3 irq_en (bit3 stored, the others self-clearing). CTRL read returns {0, irq_en, 3'b0}. NNEUR/NSTEP are read/write, taking the low bits of io_din. STATUS read returns {step_idx[STEP_W-1:0] at bits 8+, 6'b0, done, busy}.
- io_dout loads on the cycle io_rd is high and is valid the following cycle; otherwise it holds.
- Writes to NNEUR/NSTEP while busy are ignored. Start while busy is ignored.
- FSM states: IDLE, UPDATE, COMMIT, FINISH.
  - IDLE + start:
    - If NNEUR==0 or NSTEP==0: go to FINISH (no upd/cmt issued).
    - Else: neuron_idx=0, step_idx=0, done=0, go to UPDATE.
    - busy=1 from the cycle after the start write.
  - UPDATE: upd_valid=1, upd_neuron=neuron_idx, upd_step=step_idx, upd_first=(neuron_idx==0). Outputs are stable until handshake.
    - On upd_valid&upd_ready: if neuron_idx==NNEUR-1, go to COMMIT; else neuron_idx+1.
    - Back-to-back accepts are allowed: 1 request per cycle with ready held high.
  - COMMIT: cmt_valid=1, upd_step=step_idx.
    - On cmt_ready: neuron_idx=0.
    - If step_idx==NSTEP-1, go to FINISH; else step_idx+1, go to UPDATE.
  - FINISH: busy=0, done=1 (sticky), go to IDLE in the same cycle transition (FINISH lasts one cycle).
- done clears on done_clr or on an accepted start. If done_clr and a FINISH entry coincide, set wins. irq is a combinational AND of registered done and irq_en.
- Abort in any non-IDLE state: next cycle state=IDLE, upd_valid=cmt_valid=0, busy=0, done unchanged. A request pending in that cycle is withdrawn; the datapath must sample only on valid&ready.
- Abort and start in the same write: abort wins; the block ends in IDLE.
- Latency with ready tied high: start write (cycle 0), first upd_valid at cycle 1. Total = N·S + S cycles of handshake, then done at cycle N·S+S+2.
- Indices never exceed the programmed count-1; no wrap-around past the 2^W limits.

Decomposition:
- Shared package snn_pkg:
  - Register address constants (ADDR_CTRL..ADDR_STATUS).
  - CTRL bit positions.
  - FSM state encoding (2-bit localparams).
- Single module; no sub-module is warranted. The register file and FSM sit in one always block pair.

Test Plan:
- Reset mid-run: NNEUR=4, NSTEP=2, start, assert rst_n=0 after 3 accepts -> all outputs 0 immediately; registers back to 0.
- Basic run, ready high: NNEUR=3, NSTEP=2 -> upd sequence (n,s) = (0,0)(1,0)(2,0), cmt, (0,1)(1,1)(2,1), cmt; upd_first on n=0 only; done=1 and busy=0 at cycle 10 after start; STATUS reads 0x0102.
- Backpressure: upd_ready low for 5 cycles on (1,0) -> upd_neuron stays 1, upd_valid stays 1, no skipped or duplicated index; cmt_ready delayed 3 cycles -> cmt_valid held.
- Zero count: NNEUR=0, NSTEP=5, start -> no upd_valid or cmt_valid ever; done=1 two cycles after the write; with irq_en=1, irq=1; done_clr -> irq=0.
- Abort: NNEUR=8, NSTEP=4, abort at step 2 neuron 5 -> next cycle upd_valid=0, busy=0, done=0. A write of NNEUR=2 during the run is ignored (reads back 8).
- Restart: after done, start again with the same config -> done clears on start, and the sequence repeats from (0,0).

Source files
------------

// File: rtl/snn_pkg.sv
// Shared definitions for the SNN timestep scheduler: I/O register map,
// CTRL bit positions and FSM state encoding.
package snn_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_NNEUR  = 2'd1;
    localparam logic [1:0] ADDR_NSTEP  = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int CTRL_START    = 0;
    localparam int CTRL_ABORT    = 1;
    localparam int CTRL_DONE_CLR = 2;
    localparam int CTRL_IRQ_EN   = 3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_UPDATE = 2'd1,
        S_COMMIT = 2'd2,
        S_FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/snn_step_sched.sv
// Sequences one update request per neuron per timestep, then one commit per step.
// Latency: first request the cycle after start; done N*S+S+2 cycles after start (ready high).
// Backpressure: request/commit outputs hold until valid&ready; abort withdraws them.
module snn_step_sched
    import snn_pkg::*;
#(
    parameter int NEURON_W = 8,
    parameter int STEP_W   = 8,
    parameter int DATA_W   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          io_addr,
    input  logic                io_wr,
    input  logic                io_rd,
    input  logic [DATA_W-1:0]   io_din,
    output logic [DATA_W-1:0]   io_dout,
    output logic                upd_valid,
    input  logic                upd_ready,
    output logic [NEURON_W-1:0] upd_neuron,
    output logic [STEP_W-1:0]   upd_step,
    output logic                upd_first,
    output logic                cmt_valid,
    input  logic                cmt_ready,
    output logic                busy,
    output logic                done,
    output logic                irq
);

    state_t              state_q, state_d;
    logic [NEURON_W-1:0] nneur_q, nneur_d, neuron_idx_q, neuron_idx_d;
    logic [STEP_W-1:0]   nstep_q, nstep_d, step_idx_q, step_idx_d;
    logic                irq_en_q, irq_en_d, done_q, done_d;
    logic [DATA_W-1:0]   dout_q, dout_d;

    logic wr_ctrl, start_w, abort_w, clr_w, active, last_neuron, last_step;
    logic din_unused;

    assign wr_ctrl     = io_wr && (io_addr == ADDR_CTRL);
    assign start_w     = wr_ctrl && io_din[CTRL_START];
    assign abort_w     = wr_ctrl && io_din[CTRL_ABORT];
    assign clr_w       = wr_ctrl && io_din[CTRL_DONE_CLR];
    assign active      = (state_q == S_UPDATE) || (state_q == S_COMMIT);
    assign last_neuron = (neuron_idx_q == nneur_q - NEURON_W'(1));
    assign last_step   = (step_idx_q == nstep_q - STEP_W'(1));
    assign din_unused  = ^io_din;

    always_comb begin
        state_d      = state_q;
        nneur_d      = nneur_q;
        nstep_d      = nstep_q;
        neuron_idx_d = neuron_idx_q;
        step_idx_d   = step_idx_q;
        irq_en_d     = irq_en_q;
        done_d       = done_q;
        dout_d       = dout_q;

        if (io_wr && (io_addr == ADDR_NNEUR) && !active) nneur_d = io_din[NEURON_W-1:0];
        if (io_wr && (io_addr == ADDR_NSTEP) && !active) nstep_d = io_din[STEP_W-1:0];
        if (wr_ctrl) irq_en_d = io_din[CTRL_IRQ_EN];
        if (clr_w)   done_d   = 1'b0;

        if (abort_w && (state_q != S_IDLE)) begin
            // Abort freezes indices and leaves done alone so software can inspect progress.
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_w && !abort_w) begin
                        done_d       = 1'b0;
                        neuron_idx_d = '0;
                        step_idx_d   = '0;
                        state_d      = ((nneur_q == '0) || (nstep_q == '0)) ? S_FINISH : S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    if (upd_ready) begin
                        if (last_neuron) state_d = S_COMMIT;
                        else             neuron_idx_d = neuron_idx_q + NEURON_W'(1);
                    end
                end
                S_COMMIT: begin
                    if (cmt_ready) begin
                        neuron_idx_d = '0;
                        if (last_step) begin
                            state_d = S_FINISH;
                        end else begin
                            step_idx_d = step_idx_q + STEP_W'(1);
                            state_d    = S_UPDATE;
                        end
                    end
                end
                S_FINISH: begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (io_rd) begin
            dout_d = '0;
            unique case (io_addr)
                ADDR_CTRL:   dout_d[CTRL_IRQ_EN] = irq_en_q;
                ADDR_NNEUR:  dout_d = DATA_W'(nneur_q);
                ADDR_NSTEP:  dout_d = DATA_W'(nstep_q);
                ADDR_STATUS: begin
                    dout_d[8 +: STEP_W] = step_idx_q;
                    dout_d[1]           = done_q;
                    dout_d[0]           = active;
                end
                default: dout_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            nneur_q      <= '0;
            nstep_q      <= '0;
            neuron_idx_q <= '0;
            step_idx_q   <= '0;
            irq_en_q     <= 1'b0;
            done_q       <= 1'b0;
            dout_q       <= '0;
        end else begin
            state_q      <= state_d;
            nneur_q      <= nneur_d;
            nstep_q      <= nstep_d;
            neuron_idx_q <= neuron_idx_d;
            step_idx_q   <= step_idx_d;
            irq_en_q     <= irq_en_d;
            done_q       <= done_d;
            dout_q       <= dout_d;
        end
    end

    assign io_dout    = dout_q;
    assign upd_valid  = (state_q == S_UPDATE);
    assign cmt_valid  = (state_q == S_COMMIT);
    assign upd_neuron = upd_valid ? neuron_idx_q : '0;
    assign upd_step   = active ? step_idx_q : '0;
    assign upd_first  = upd_valid && (neuron_idx_q == '0);
    assign busy       = active;
    assign done       = done_q;
    assign irq        = done_q && irq_en_q;

endmodule

// File: tb/tb_snn_step_sched.sv
// Scoreboard bench for snn_step_sched: stimulus queues expected handshakes,
// a negedge monitor pops and compares every accepted update/commit.
module tb_snn_step_sched;
    import snn_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  io_addr = '0;
    logic        io_wr = 1'b0;
    logic        io_rd = 1'b0;
    logic [15:0] io_din = '0;
    logic [15:0] io_dout;
    logic        upd_valid, upd_first, cmt_valid, busy, done, irq;
    logic        upd_ready = 1'b1;
    logic        cmt_ready = 1'b1;
    logic [7:0]  upd_neuron, upd_step;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic       is_cmt;
        logic [7:0] n;
        logic [7:0] s;
        logic       first;
    } exp_t;

    exp_t sb[$];

    snn_step_sched #(.NEURON_W(8), .STEP_W(8), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .io_addr(io_addr), .io_wr(io_wr), .io_rd(io_rd),
        .io_din(io_din), .io_dout(io_dout), .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_neuron(upd_neuron), .upd_step(upd_step), .upd_first(upd_first),
        .cmt_valid(cmt_valid), .cmt_ready(cmt_ready), .busy(busy), .done(done), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic pop_cmp(input string name, input exp_t act);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s unexpected handshake actual=0x%0h expected=none", name, act);
        end else begin
            e = sb.pop_front();
            chk(name, 32'(act), 32'(e));
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (upd_valid && upd_ready) pop_cmp("sb_upd", {1'b0, upd_neuron, upd_step, upd_first});
                if (cmt_valid && cmt_ready) pop_cmp("sb_cmt", {1'b1, 8'd0, upd_step, 1'b0});
            end
        end
    end

    task automatic push_run(input int n, input int s);
        for (int st = 0; st < s; st++) begin
            for (int ne = 0; ne < n; ne++)
                sb.push_back({1'b0, 8'(ne), 8'(st), (ne == 0)});
            sb.push_back({1'b1, 8'd0, 8'(st), 1'b0});
        end
    endtask

    // Called at posedge+1; the write lands on the next rising edge.
    task automatic io_write(input logic [1:0] a, input logic [15:0] d);
        io_addr = a; io_din = d; io_wr = 1'b1;
        @(posedge clk); #1;
        io_wr = 1'b0; io_din = '0;
    endtask

    task automatic io_read(input logic [1:0] a, output logic [15:0] d);
        io_addr = a; io_rd = 1'b1;
        @(posedge clk); #1;
        io_rd = 1'b0;
        d = io_dout;
    endtask

    task automatic wait_done(input int budget, input string name);
        int k = 0;
        while (!done && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        chk(name, 32'(done), 32'd1);
    endtask

    logic [15:0] rd;

    initial begin
        // Reset state
        #2;
        chk("rst_outputs", {io_dout, upd_valid, cmt_valid, busy, done, irq, upd_first},
            32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic run, ready high
        io_write(ADDR_NNEUR, 16'd3);
        io_write(ADDR_NSTEP, 16'd2);
        push_run(3, 2);
        io_write(ADDR_CTRL, 16'h0001);
        chk("basic_c1_busy", 32'(busy), 32'd1);
        chk("basic_c1_first", {upd_valid, upd_first, upd_neuron, upd_step}, {2'b11, 16'h0000});
        repeat (8) begin @(posedge clk); #1; end
        chk("basic_c9_busy_done", {busy, done}, 32'b00);
        @(posedge clk); #1;
        chk("basic_c10_busy_done", {busy, done}, 32'b01);
        io_read(ADDR_STATUS, rd);
        chk("basic_status", 32'(rd), 32'h0102);
        chk("basic_sb_empty", 32'(sb.size()), 32'd0);

        // Backpressure on update (1,0) and on commit
        io_write(ADDR_NSTEP, 16'd1);
        push_run(3, 1);
        cmt_ready = 1'b0;
        io_write(ADDR_CTRL, 16'h0001);
        @(posedge clk); #1;
        upd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_upd_hold", {upd_valid, upd_neuron}, {1'b1, 8'd1});
            @(posedge clk); #1;
        end
        upd_ready = 1'b1;
        for (int i = 0; i < 20 && !cmt_valid; i++) begin @(posedge clk); #1; end
        for (int i = 0; i < 3; i++) begin
            chk("bp_cmt_hold", {cmt_valid, upd_valid}, 32'b10);
            @(posedge clk); #1;
        end
        cmt_ready = 1'b1;
        wait_done(20, "bp_done");
        chk("bp_sb_empty", 32'(sb.size()), 32'd0);

        // Zero neuron count with irq enabled
        io_write(ADDR_NNEUR, 16'd0);
        io_write(ADDR_NSTEP, 16'd5);
        io_write(ADDR_CTRL, 16'h0009);
        chk("zero_c1", {upd_valid, cmt_valid, busy, done}, 32'b0000);
        @(posedge clk); #1;
        chk("zero_c2", {upd_valid, cmt_valid, done, irq}, 32'b0011);
        io_read(ADDR_CTRL, rd);
        chk("zero_ctrl_rd", 32'(rd), 32'h0008);
        io_write(ADDR_CTRL, 16'h000C);
        chk("zero_clr", {done, irq}, 32'b00);

        // Abort at step 2 neuron 5; NNEUR write while busy ignored
        io_write(ADDR_NNEUR, 16'd8);
        io_write(ADDR_NSTEP, 16'd4);
        push_run(8, 2);
        for (int ne = 0; ne < 5; ne++) sb.push_back({1'b0, 8'(ne), 8'd2, (ne == 0)});
        io_write(ADDR_CTRL, 16'h0009);
        io_write(ADDR_NNEUR, 16'd2);
        for (int i = 0; i < 60; i++) begin
            if (upd_valid && upd_neuron == 8'd5 && upd_step == 8'd2) begin
                upd_ready = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        chk("abort_reached", {upd_valid, upd_neuron, upd_step}, {1'b1, 8'd5, 8'd2});
        io_write(ADDR_CTRL, 16'h000A);
        chk("abort_next", {upd_valid, cmt_valid, busy, done}, 32'b0000);
        upd_ready = 1'b1;
        @(posedge clk); #1;
        chk("abort_stays_idle", {upd_valid, busy}, 32'b00);
        io_read(ADDR_NNEUR, rd);
        chk("abort_nneur_rd", 32'(rd), 32'd8);
        chk("abort_sb_empty", 32'(sb.size()), 32'd0);

        // Restart with same configuration after done
        io_write(ADDR_NNEUR, 16'd2);
        io_write(ADDR_NSTEP, 16'd1);
        push_run(2, 1);
        io_write(ADDR_CTRL, 16'h0009);
        wait_done(20, "restart_first_done");
        chk("restart_irq", 32'(irq), 32'd1);
        push_run(2, 1);
        io_write(ADDR_CTRL, 16'h0009);
        chk("restart_clears_done", {done, irq, upd_valid, upd_first, upd_neuron, upd_step},
            {4'b0011, 16'h0000});
        wait_done(20, "restart_second_done");
        chk("restart_sb_empty", 32'(sb.size()), 32'd0);

        // Reset in the middle of a run after three accepts
        io_write(ADDR_NNEUR, 16'd4);
        io_write(ADDR_NSTEP, 16'd2);
        for (int ne = 0; ne < 3; ne++) sb.push_back({1'b0, 8'(ne), 8'd0, (ne == 0)});
        io_write(ADDR_CTRL, 16'h0009);
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {io_dout, upd_valid, cmt_valid, busy, done, irq, upd_first,
            upd_neuron, upd_step}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        io_read(ADDR_NNEUR, rd);
        chk("midrst_nneur", 32'(rd), 32'd0);
        io_read(ADDR_NSTEP, rd);
        chk("midrst_nstep", 32'(rd), 32'd0);
        io_read(ADDR_CTRL, rd);
        chk("midrst_ctrl", 32'(rd), 32'd0);
        chk("midrst_sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
